// File: rtl/trng_source_sel.sv
// rtl/trng_source_sel.sv - glitch-free entropy-source selector with settle window and decimated sample output
// Optional feature macro: TRNG_SEL_XOR_EN (adds mode_xor_i and XOR-combine of all sources)
module trng_source_sel #(
  parameter  int NUM_SRC     = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int SETTLE      = 8,
  parameter  int SAMPLE_DIV  = 4,
  localparam int SEL_W       = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               sel_req_i,
`ifdef TRNG_SEL_XOR_EN
  input  logic               mode_xor_i,
`endif
  output logic               sel_ack_o,
  output logic               sel_err_o,
  output logic               busy_o,
  output logic [SEL_W-1:0]   cur_sel_o,
  output logic               bit_o,
  output logic               bit_valid_o
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(SETTLE - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_last;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic               bit_q, bit_d;
  logic               valid_q, valid_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
`ifdef TRNG_SEL_XOR_EN
  logic               mode_q, mode_d;
`endif

  logic               sel_bit;
  logic               sample_bit;
  logic               sel_in_range;

  // Synchroniser shift: stage 0 captures the raw oscillators, later stages re-time
  always_comb begin
    for (int s = 0; s < SYNC_STAGES; s++) begin
      sync_d[s] = '0;
    end
    sync_d[0] = src_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_last    = sync_q[SYNC_STAGES-1];
  assign sel_in_range = ({1'b0, sel_i} < NUM_SRC_W);

  // Pick the synchronised bit of the routed source (or the XOR of all sources)
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_sel_q == SEL_W'(i)) begin
        sel_bit = sync_last[i];
      end
    end
`ifdef TRNG_SEL_XOR_EN
    sample_bit = mode_q ? (^sync_last) : sel_bit;
`else
    sample_bit = sel_bit;
`endif
  end

  // Next-state logic: settle countdown, divider, request accept/reject
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    cur_sel_d = cur_sel_q;
    bit_d     = bit_q;
    valid_d   = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
`ifdef TRNG_SEL_XOR_EN
    mode_d    = mode_q;
`endif
    case (state_q)
      ST_SETTLE: begin
        div_d = '0;
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (sel_req_i && sel_in_range) begin
          // Accepting restarts the settle window and drops any sample due on this edge
          ack_d     = 1'b1;
          cur_sel_d = sel_i;
          state_d   = ST_SETTLE;
          cnt_d     = CNT_INIT;
          div_d     = '0;
`ifdef TRNG_SEL_XOR_EN
          mode_d    = mode_xor_i;
`endif
        end else begin
          err_d = sel_req_i;
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            valid_d = 1'b1;
            bit_d   = sample_bit;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
    endcase
    busy_d = (state_d != ST_ACTIVE);
  end

  // All state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      state_q   <= ST_SETTLE;
      cnt_q     <= CNT_INIT;
      div_q     <= '0;
      cur_sel_q <= '0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b1;
`ifdef TRNG_SEL_XOR_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      cur_sel_q <= cur_sel_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef TRNG_SEL_XOR_EN
      mode_q    <= mode_d;
`endif
    end
  end

  assign sel_ack_o   = ack_q;
  assign sel_err_o   = err_q;
  assign busy_o      = busy_q;
  assign cur_sel_o   = cur_sel_q;
  assign bit_o       = bit_q;
  assign bit_valid_o = valid_q;

endmodule

// File: doc/trng_source_sel.md
# trng_source_sel

Parametrised, glitch-free entropy-source selector for the TRNG datapath. Takes `NUM_SRC` free-running asynchronous entropy bits (ring-oscillator outputs), synchronises each into the `clk` domain, and routes one of them to a decimated sample stream. Selection changes use a request/acknowledge handshake followed by a settle window, so no sample ever mixes old and new sources. It sits between the oscillator bank and the whitening/post-processing stage, and replaces the fixed two-input transistor-level selector.

## Interface
- `NUM_SRC`, 4: number of entropy inputs, ≥2. Derived localparam `SEL_W = $clog2(NUM_SRC)`.
- `SYNC_STAGES`, 2: synchroniser depth per source, ≥2.
- `SETTLE`, 8: cycles of suppressed output after a selection change or reset, ≥1.
- `SAMPLE_DIV`, 4: clock cycles per emitted sample, ≥1.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_i`  in  NUM_SRC  asynchronous entropy bits.
- `sel_i`  in  SEL_W  requested source index.
- `sel_req_i`  in  1  selection request, sampled on `clk`.
- `mode_xor_i`  in  1  requested XOR-combine mode (present only with `TRNG_SEL_XOR_EN`).
- `sel_ack_o`  out  1  one-cycle pulse: request accepted.
- `sel_err_o`  out  1  one-cycle pulse: request rejected, index out of range.
- `busy_o`  out  1  high while not in ACTIVE.
- `cur_sel_o`  out  SEL_W  currently routed source.
- `bit_o`  out  1  sampled entropy bit.
- `bit_valid_o`  out  1  one-cycle strobe qualifying `bit_o`.

## Operation
- Synchroniser: `SYNC_STAGES` flops per source, all reset to 0. Only the last stage is used.
- FSM has two states. Both are registered, along with the settle counter `cnt` and the divider `div`.
  - SETTLE: `bit_valid_o`=0 and `div` held at 0. `cnt` decrements by 1 per cycle. When `cnt`==0, the FSM moves to ACTIVE.
  - ACTIVE: `div` counts 0..SAMPLE_DIV-1 and wraps. On the wrap edge, `bit_valid_o`=1 and `bit_o` is loaded with the synchronised bit of `cur_sel_o`.
- A request is `sel_req_i`=1 sampled in ACTIVE.
  - If `sel_i` < NUM_SRC, the request is accepted: `sel_ack_o` pulses, `cur_sel_o` is loaded with `sel_i`, the FSM enters SETTLE, and `cnt` is loaded with SETTLE-1. This happens even when `sel_i` equals `cur_sel_o`.
  - If `sel_i` ≥ NUM_SRC, the request is rejected: `sel_err_o` pulses and there is no state change.
- Requests sampled in SETTLE are ignored: no ack and no error. The requester must hold `sel_req_i` until it sees `sel_ack_o` or `sel_err_o`.
- Simultaneous events:
  - A request accepted on the same edge as a `div` wrap suppresses that sample. `bit_valid_o` stays 0 and `bit_o` holds its value.
  - A held request is re-evaluated every ACTIVE cycle. After an ack the requester must deassert, otherwise it re-triggers SETTLE.
- `bit_o` holds its last value between strobes.
- Reset mid-operation: asynchronous return to reset values. Any settle in progress is abandoned.
- Reset values: state=SETTLE, `cnt`=SETTLE-1, `div`=0, `cur_sel_o`=0, `bit_o`=0, `bit_valid_o`=0, `sel_ack_o`=0, `sel_err_o`=0, `busy_o`=1.

## Timing
- A request is accepted at edge k.
  - At edge k: `sel_ack_o`=1, `cur_sel_o`=new index, `busy_o`=1.
  - At edge k+SETTLE: state is ACTIVE and `busy_o`=0.
  - At edge k+SETTLE+SAMPLE_DIV: first `bit_valid_o`, carrying the new source.
- After reset release, the first `bit_valid_o` comes at the SETTLE+SAMPLE_DIV-th edge.
- Steady state: one strobe every SAMPLE_DIV cycles. With SAMPLE_DIV=1, `bit_valid_o` is high continuously in ACTIVE.
- Source-to-sample latency: SYNC_STAGES edges, plus wait for the next wrap, plus 1.
- `sel_ack_o` and `sel_err_o` are registered and last exactly one cycle.

## Configuration
- `TRNG_SEL_XOR_EN` defined:
  - Port `mode_xor_i` and an internal `mode` register (reset 0) exist.
  - `mode` is captured from `mode_xor_i` on an accepted request, through the same SETTLE sequence.
  - With `mode`=1, the sampled bit is the XOR of all synchronised sources, and `cur_sel_o` is still updated.
- Not defined: the port and register are absent, and the block always samples a single source.

## Test plan
- Reset release, NUM_SRC=4, SETTLE=8, SAMPLE_DIV=4, `src_i`=4'b0100, no request -> `busy_o` falls at edge 8; the first `bit_valid_o` comes at edge 12 with `bit_o`=0 (source 0); strobes repeat every 4 cycles.
- In ACTIVE, `sel_i`=2 with `sel_req_i` held until ack -> one `sel_ack_o`, `cur_sel_o`=2, no strobe for the next 8+4 edges, then `bit_o`=1.
- `sel_i`=5 with NUM_SRC=5 -> `sel_err_o` pulses once; `cur_sel_o`, strobe cadence and `busy_o` are unchanged.
- Request held through SETTLE -> no ack or error during SETTLE; ack on the first ACTIVE cycle.
- Request accepted on the `div` wrap edge -> that strobe is suppressed and `bit_o` is unchanged; `rst_n` asserted mid-SETTLE -> all outputs go to reset values immediately.
- `TRNG_SEL_XOR_EN`, `mode_xor_i`=1 request, `src_i`=4'b0111 -> after settle, every strobe gives `bit_o`=1; `src_i`=4'b0011 gives `bit_o`=0.
